// File: rtl/multicycle_ctrl_if.sv
// Controller <-> instruction memory / datapath signal bundle.
// master = controller side, slave = memory/datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [D_WIDTH-1:0]   instr;
  logic                 imem_valid;
  logic                 EQ;
  logic                 imem_req;
  logic [D_WIDTH-1:0]   ir;
  logic                 pc_en;
  logic                 PCsrc;
  logic                 RegWrite;
  logic                 ALUsrc;
  logic                 ALUctrl;
  logic                 ImmSrc;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  instr, imem_valid, EQ,
    output imem_req, ir, pc_en, PCsrc, RegWrite, ALUsrc, ALUctrl, ImmSrc,
           illegal, retired
  );

  modport slave (
    output instr, imem_valid, EQ,
    input  imem_req, ir, pc_en, PCsrc, RegWrite, ALUsrc, ALUctrl, ImmSrc,
           illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute controller for addi and bne, with a sticky
// illegal-instruction trap and a saturating retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [CNT_WIDTH-1:0] RET_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_I = 3'd2,
    EXEC_B = 3'd3,
    TRAP   = 3'd4
  } state_e;

  // Moore controls, registered from the state being entered.
  typedef struct packed {
    logic imem_req;
    logic pc_en;
    logic reg_write;
    logic alu_src;
    logic alu_ctrl;
    logic imm_src;
    logic exec_b;
  } ctrl_t;

  state_e               state_q, state_d;
  logic [D_WIDTH-1:0]   ir_q, ir_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 illegal_q, illegal_d;
  ctrl_t                ctrl_q, ctrl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    ctrl_d    = '0;

    case (state_q)
      // The request is only live from the first edge after reset onward.
      FETCH: begin
        if (ctrl_q.imem_req && bus.imem_valid) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (ir_q[6:0] == OPC_OP_IMM && ir_q[14:12] == F3_ADDI) begin
          state_d = EXEC_I;
        end else if (ir_q[6:0] == OPC_BRANCH && ir_q[14:12] == F3_BNE) begin
          state_d = EXEC_B;
        end else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      EXEC_I, EXEC_B: begin
        state_d = FETCH;
        if (retired_q != RET_MAX) begin
          retired_d = retired_q + CNT_WIDTH'(1);
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase

    case (state_d)
      FETCH: ctrl_d.imem_req = 1'b1;
      EXEC_I: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.pc_en     = 1'b1;
        ctrl_d.reg_write = |ir_d[11:7];
      end
      EXEC_B: begin
        ctrl_d.alu_ctrl = 1'b1;
        ctrl_d.imm_src  = 1'b1;
        ctrl_d.pc_en    = 1'b1;
        ctrl_d.exec_b   = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  assign bus.imem_req = ctrl_q.imem_req;
  assign bus.ir       = ir_q;
  assign bus.pc_en    = ctrl_q.pc_en;
  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.ALUsrc   = ctrl_q.alu_src;
  assign bus.ALUctrl  = ctrl_q.alu_ctrl;
  assign bus.ImmSrc   = ctrl_q.imm_src;
  // Branch direction follows the live EQ flag during the branch cycle.
  assign bus.PCsrc    = ctrl_q.exec_b & ~bus.EQ;
  assign bus.illegal  = illegal_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction
// streams compared against a transaction-level model of the controller.
module tb_multicycle_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 3;
  localparam int          MAXR = (1 << CW) - 1;
  localparam int          C_ADDI = 0, C_BNE = 1, C_TRAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_retired = 0;
  logic [DW-1:0] prev_ir = '0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.D_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  multicycle_ctrl #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {imem_req, pc_en, RegWrite, ALUsrc, ALUctrl, ImmSrc, PCsrc, illegal}
  function automatic logic [7:0] obs_vec();
    return {bus.imem_req, bus.pc_en, bus.RegWrite, bus.ALUsrc, bus.ALUctrl,
            bus.ImmSrc, bus.PCsrc, bus.illegal};
  endfunction

  function automatic int classify(input logic [31:0] x);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = x[6:0];
    f3  = x[14:12];
    if (opc == 7'h13 && f3 == 3'd0) return C_ADDI;
    if (opc == 7'h63 && f3 == 3'd1) return C_BNE;
    return C_TRAP;
  endfunction

  function automatic logic [7:0] exec_vec(input int cls, input logic [31:0] x, input logic eq);
    logic [4:0] rd;
    rd = x[11:7];
    if (cls == C_ADDI) return {1'b0, 1'b1, (rd != 5'd0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    if (cls == C_BNE)  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ~eq, 1'b0};
    return 8'b0000_0001;
  endfunction

  function automatic int exp_ret();
    return (n_retired > MAXR) ? MAXR : n_retired;
  endfunction

  task automatic do_reset();
    bus.imem_valid = 1'b0;
    bus.instr      = '0;
    bus.EQ         = 1'b0;
    rst_n          = 1'b0;
    #1;
    chk("rst_outputs", 32'(obs_vec()), 32'h0);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_retired", 32'(bus.retired), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_release_req", 32'(bus.imem_req), 32'h0);
    tick();
    chk("first_edge_req", 32'(obs_vec()), 32'h80);
    n_retired = 0;
    prev_ir   = '0;
  endtask

  // One instruction: gap idle FETCH cycles, accept, DECODE, EXEC (or TRAP).
  task automatic run_instr(input logic [31:0] x, input int gap, input logic eq, input logic junk);
    int cls;
    cls = classify(x);
    for (int g = 0; g < gap; g++) begin
      bus.imem_valid = 1'b0;
      bus.instr      = $urandom;
      tick();
      chk("wait_fetch", 32'(obs_vec()), 32'h80);
      chk("wait_ir_hold", bus.ir, prev_ir);
    end
    bus.instr      = x;
    bus.imem_valid = 1'b1;
    tick();
    chk("decode_ir", bus.ir, x);
    chk("decode_ctrl", 32'(obs_vec()), 32'h0);
    bus.imem_valid = junk;
    bus.instr      = $urandom;
    bus.EQ         = eq;
    tick();
    chk("exec_ctrl", 32'(obs_vec()), 32'(exec_vec(cls, x, eq)));
    chk("exec_ir_hold", bus.ir, x);
    chk("exec_retired", 32'(bus.retired), 32'(exp_ret()));
    if (cls == C_BNE) begin
      bus.EQ = ~eq;
      #1;
      chk("bne_pcsrc_live", 32'(bus.PCsrc), 32'(eq));
    end
    bus.imem_valid = 1'b0;
    if (cls != C_TRAP) begin
      tick();
      n_retired++;
      chk("back_fetch", 32'(obs_vec()), 32'h80);
      chk("retired", 32'(bus.retired), 32'(exp_ret()));
      prev_ir = x;
    end
  endtask

  function automatic logic [31:0] rand_addi();
    logic [4:0] rd;
    logic [31:0] r;
    r  = $urandom;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return {r[31:15], 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_bne();
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], 3'b001, r[11:7], 7'b1100011};
  endfunction

  initial begin
    logic [31:0] w;
    do_reset();

    run_instr(32'h0050_0093, 0, 1'b0, 1'b0);  // addi x1,x0,5
    run_instr(32'h0020_9463, 0, 1'b0, 1'b1);  // bne, not equal -> taken
    run_instr(32'h0020_9463, 1, 1'b1, 1'b0);  // bne, equal -> not taken
    run_instr(32'h0050_0093, 4, 1'b0, 1'b1);  // four idle FETCH cycles
    run_instr(32'h0010_0013, 0, 1'b1, 1'b0);  // addi x0,x0,1

    for (int i = 0; i < 30; i++) begin
      w = ($urandom_range(0, 1) == 0) ? rand_addi() : rand_bne();
      run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("saturated", 32'(bus.retired), 32'(MAXR));

    // Reset asserted in the middle of an addi execute cycle.
    bus.instr      = 32'h0050_0093;
    bus.imem_valid = 1'b1;
    tick();
    bus.imem_valid = 1'b0;
    tick();
    chk("pre_abort_regwrite", 32'(bus.RegWrite), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 32'(obs_vec()), 32'h0);
    chk("abort_retired", 32'(bus.retired), 32'h0);
    chk("abort_ir", bus.ir, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_fetch", 32'(obs_vec()), 32'h80);
    n_retired = 0;
    prev_ir   = '0;
    run_instr(rand_addi(), 0, 1'b0, 1'b0);

    // Unsupported instruction traps permanently until reset.
    run_instr(32'h0000_0033, 1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.imem_valid = 1'b1;
      bus.instr      = rand_addi();
      tick();
      chk("trap_hold", 32'(obs_vec()), 32'h01);
      chk("trap_ir", bus.ir, 32'h0000_0033);
      chk("trap_retired", 32'(bus.retired), 32'(exp_ret()));
    end
    bus.imem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("trap_clear", 32'(bus.illegal), 32'h0);
    tick();
    do_reset();
    run_instr(32'h0020_9463, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter D_WIDTH, default 32: instruction and ir width.
REQ-002 Parameter CNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instr  input  D_WIDTH  instruction word from instruction memory.
REQ-006 imem_valid  input  1  instr is valid this cycle.
REQ-007 EQ  input  1  ALU equality flag from the datapath.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 ir  output  D_WIDTH  latched instruction register; feeds rs1/rs2/rd/immediate fields.
REQ-010 pc_en  output  1  PC register update enable, one-cycle pulse.
REQ-011 PCsrc  output  1  PC mux select: 0 = PC+4, 1 = PC+ImmOp.
REQ-012 RegWrite  output  1  register-file write enable.
REQ-013 ALUsrc  output  1  ALU operand-2 select: 0 = register, 1 = ImmOp.
REQ-014 ALUctrl  output  1  ALU operation: 0 = add, 1 = subtract/compare.
REQ-015 ImmSrc  output  1  immediate format: 0 = I-type, 1 = B-type.
REQ-016 illegal  output  1  sticky flag: unsupported instruction decoded.
REQ-017 retired  output  CNT_WIDTH  count of completed instructions.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC_I, EXEC_B and TRAP.
REQ-019 FETCH SHALL drive imem_req=1. On imem_valid=1 it SHALL load ir<=instr and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-020 imem_valid in any state other than FETCH SHALL be ignored, and ir SHALL hold.
REQ-021 DECODE SHALL classify ir:
- opcode 0010011 with funct3 000 (addi) -> EXEC_I.
- opcode 1100011 with funct3 001 (bne) -> EXEC_B.
- anything else -> TRAP.
REQ-022 EXEC_I SHALL drive ALUsrc=1, ALUctrl=0, ImmSrc=0, PCsrc=0, pc_en=1 and RegWrite=1 for exactly one cycle, then go to FETCH.
REQ-023 In EXEC_I, RegWrite SHALL be 0 when ir[11:7]==0 (rd=x0); pc_en and retired are unaffected.
REQ-024 EXEC_B SHALL drive ALUsrc=0, ALUctrl=1, ImmSrc=1, RegWrite=0, pc_en=1 and PCsrc=~EQ, using the EQ value in that cycle, then go to FETCH.
REQ-025 Outside EXEC_I/EXEC_B, pc_en, RegWrite and PCsrc SHALL be 0. ALUsrc, ALUctrl and ImmSrc SHALL be 0 in FETCH, DECODE and TRAP.
REQ-026 All control outputs SHALL be decoded from the current state and ir (Moore), except PCsrc, which is combinational from EQ in EXEC_B.
REQ-027 retired SHALL increment by 1 on the clock edge leaving EXEC_I or EXEC_B, and SHALL saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-028 TRAP SHALL be absorbing until reset, with illegal=1, imem_req=0 and all enables 0.
REQ-029 Minimum latency SHALL be 3 cycles per instruction (FETCH with imem_valid high, DECODE, EXEC). Each cycle of imem_valid low in FETCH adds one cycle.
REQ-030 A reset asserted mid-instruction SHALL abort it with no RegWrite or pc_en pulse after assertion.

Reset
REQ-031 While rst_n=0, asynchronously:
- state=FETCH;
- ir=0, retired=0, illegal=0;
- all outputs 0, including imem_req.
REQ-032 imem_req SHALL rise on the first rising clk edge after rst_n deasserts, with the FSM in FETCH.

Verification
REQ-033 Reset, then instr=0x00500093 (addi x1,x0,5) with imem_valid=1 -> ir=0x00500093 after 1 cycle; in cycle 3, RegWrite=1, ALUsrc=1, pc_en=1, PCsrc=0; retired=1.
REQ-034 bne with EQ=0 -> EXEC_B shows PCsrc=1, ImmSrc=1, ALUctrl=1, RegWrite=0. Repeat with EQ=1 -> PCsrc=0, pc_en=1.
REQ-035 imem_valid held low 4 cycles in FETCH -> imem_req stays 1, no DECODE, ir unchanged; the instruction completes on cycle 7.
REQ-036 instr=0x00000033 (add, unsupported) -> after DECODE, illegal=1 and imem_req=0 permanently. A further imem_valid pulse causes no change; rst_n low clears illegal.
REQ-037 addi x0,x0,1 -> RegWrite stays 0, pc_en=1, retired increments. With CNT_WIDTH=2, 5 instructions -> retired=3 (saturated).
REQ-038 rst_n pulsed low during EXEC_I -> RegWrite and pc_en drop immediately, state=FETCH, retired keeps its reset value 0.
